// File: rtl/apply_sign_pipe.sv
// apply_sign_pipe: restores two's-complement values from {magnitude, sign} beats. It works as one 32-bit lane or as two 16-bit lanes.
// Latency: 2 register stages. A beat presented in cycle N shows on Out in cycle N+2 when the pipe is not stalled.
// Backpressure: in_ready = !out_valid || out_ready. Both stages freeze together while Out is stalled.
//
// Ports:
//   clk, rst            rising-edge clock; synchronous active-high reset
//   in_valid/in_ready   input handshake for {In, popsign, mode}
//   In[31:0]            unsigned magnitude; in dual mode In[31:16] is lane 1 and In[15:0] is lane 2
//   popsign[1:0]        bit0 is the sign for 32-bit mode and for lane 2; bit1 is the sign for lane 1
//   mode                0 = one 32-bit lane; 1 = two independent 16-bit lanes
//   out_valid/out_ready output handshake for {Out, ovf}
//   Out[31:0]           two's-complement result, packed the same way as In
//   ovf[1:0]            per-lane overflow; bit0 is for 32-bit mode and lane 2
//   ovf_count[7:0]      saturating count of beats entering stage 2 with any overflow
//
// Build option APPLY_SIGN_SAT_EN: an overflowing lane saturates to its max or min value.
// Without it, the lane wraps. Both builds raise the ovf flag.

module apply_sign_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] In,
  input  logic [1:0]  popsign,
  input  logic        mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Out,
  output logic [1:0]  ovf,
  output logic [7:0]  ovf_count
);

  // Stage 1: registered copy of the accepted beat.
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_mag_q,   s1_mag_d;
  logic [1:0]  s1_sgn_q,   s1_sgn_d;
  logic        s1_mode_q,  s1_mode_d;

  // Stage 2: registered result.
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_q,       out_d;
  logic [1:0]  ovf_q,       ovf_d;
  logic [7:0]  ovf_count_q, ovf_count_d;

  logic        advance;

  // Result of one 16-bit lane. Bit 16 is the overflow flag; bits 15:0 hold the value.
  function automatic logic [16:0] apply16(input logic [15:0] mag, input logic sgn);
    logic [15:0] res;
    logic        o;
    // A negative lane can reach 0x8000. A positive lane must stay below it.
    o   = sgn ? (mag > 16'h8000) : mag[15];
    res = sgn ? (~mag + 16'd1) : mag;
`ifdef APPLY_SIGN_SAT_EN
    if (o) res = sgn ? 16'h8000 : 16'h7FFF;
`endif
    return {o, res};
  endfunction

  logic [31:0] res32;
  logic        ovf32;
  logic [16:0] lane_hi;
  logic [16:0] lane_lo;
  logic [31:0] res_calc;
  logic [1:0]  ovf_calc;

  // Compute from stage 1. In dual mode each lane has its own 16-bit add, so no carry passes between bit 15 and bit 16.
  always_comb begin
    ovf32 = s1_sgn_q[0] ? (s1_mag_q > 32'h8000_0000) : s1_mag_q[31];
    res32 = s1_sgn_q[0] ? (~s1_mag_q + 32'd1) : s1_mag_q;
`ifdef APPLY_SIGN_SAT_EN
    if (ovf32) res32 = s1_sgn_q[0] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    lane_hi = apply16(s1_mag_q[31:16], s1_sgn_q[1]);
    lane_lo = apply16(s1_mag_q[15:0],  s1_sgn_q[0]);
    if (s1_mode_q) begin
      res_calc = {lane_hi[15:0], lane_lo[15:0]};
      ovf_calc = {lane_hi[16], lane_lo[16]};
    end else begin
      res_calc = res32;
      ovf_calc = {1'b0, ovf32};
    end
  end

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_mag_d    = s1_mag_q;
    s1_sgn_d    = s1_sgn_q;
    s1_mode_d   = s1_mode_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    ovf_d       = ovf_q;
    ovf_count_d = ovf_count_q;
    if (advance) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_mag_d  = In;
        s1_sgn_d  = popsign;
        s1_mode_d = mode;
      end
      // A bubble in stage 1 becomes out_valid = 0. The last data stays on Out.
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d = res_calc;
        ovf_d = ovf_calc;
        if ((|ovf_calc) && (ovf_count_q != 8'hFF))
          ovf_count_d = ovf_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mag_q    <= '0;
      s1_sgn_q    <= '0;
      s1_mode_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      ovf_q       <= '0;
      ovf_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mag_q    <= s1_mag_d;
      s1_sgn_q    <= s1_sgn_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Out       = out_q;
  assign ovf       = ovf_q;
  assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_apply_sign_pipe.sv
// Directed bench for apply_sign_pipe. The expected values are worked out by hand in each step.
// Inputs are driven 1 ns after the rising edge. Outputs are sampled at that same point, or at the falling edge.
// Define APPLY_SIGN_SAT_EN for both the bench and the RTL to select the saturating expectations.

module tb_apply_sign_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] In;
  logic [1:0]  popsign;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Out;
  logic [1:0]  ovf;
  logic [7:0]  ovf_count;

  int total = 0;
  int bad   = 0;

  apply_sign_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .In        (In),
    .popsign   (popsign),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out),
    .ovf       (ovf),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one beat for one cycle. Two cycles later, check the result.
  task automatic beat(input string tag, input logic m, input logic [31:0] mag, input logic [1:0] sg,
                      input logic [31:0] exp_out, input logic [1:0] exp_ovf);
    in_valid = 1'b1; mode = m; In = mag; popsign = sg;
    step();
    in_valid = 1'b0;
    step();
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_out"}, Out, exp_out);
    chk({tag, "_ovf"}, {30'd0, ovf}, {30'd0, exp_ovf});
  endtask

  int idx, got, stall_left;
  bit first_seen, stalled;

  initial begin
    rst = 1'b1; in_valid = 1'b0; In = '0; popsign = '0; mode = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", Out, 32'd0);
    chk("rst_ovf", {30'd0, ovf}, 32'd0);
    chk("rst_cnt", {24'd0, ovf_count}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 32-bit lane cases.
    beat("neg5", 1'b0, 32'h0000_0005, 2'b01, 32'hFFFF_FFFB, 2'b00);
    beat("minneg32", 1'b0, 32'h8000_0000, 2'b01, 32'h8000_0000, 2'b00);
`ifdef APPLY_SIGN_SAT_EN
    beat("pos_ovf32", 1'b0, 32'h8000_0000, 2'b00, 32'h7FFF_FFFF, 2'b01);
    beat("neg_ovf32", 1'b0, 32'hFFFF_FFFF, 2'b01, 32'h8000_0000, 2'b01);
`else
    beat("pos_ovf32", 1'b0, 32'h8000_0000, 2'b00, 32'h8000_0000, 2'b01);
    beat("neg_ovf32", 1'b0, 32'hFFFF_FFFF, 2'b01, 32'h0000_0001, 2'b01);
`endif
    beat("ign_sgn1", 1'b0, 32'h0000_0005, 2'b10, 32'h0000_0005, 2'b00);
    beat("neg_zero32", 1'b0, 32'h0000_0000, 2'b01, 32'h0000_0000, 2'b00);

    // Dual 16-bit lane cases.
`ifdef APPLY_SIGN_SAT_EN
    beat("dual_lo_ovf", 1'b1, 32'h0003_8001, 2'b10, 32'hFFFD_7FFF, 2'b01);
    beat("dual_hi_ovf", 1'b1, 32'h8001_8000, 2'b11, 32'h8000_8000, 2'b10);
`else
    beat("dual_lo_ovf", 1'b1, 32'h0003_8001, 2'b10, 32'hFFFD_8001, 2'b01);
    beat("dual_hi_ovf", 1'b1, 32'h8001_8000, 2'b11, 32'h7FFF_8000, 2'b10);
`endif
    beat("dual_minneg", 1'b1, 32'h8000_8000, 2'b11, 32'h8000_8000, 2'b00);
    beat("dual_zero", 1'b1, 32'h0000_0000, 2'b11, 32'h0000_0000, 2'b00);
    chk("cnt_after_dir", {24'd0, ovf_count}, 32'd4);

    // Consecutive beats with a mode change between them. No bubble is allowed.
    in_valid = 1'b1; mode = 1'b0; In = 32'h0000_0005; popsign = 2'b01;
    step();
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    mode = 1'b1; In = 32'h0003_0004; popsign = 2'b11;
    step();
    in_valid = 1'b0;
    chk("b2b_a_vld", {31'd0, out_valid}, 32'd1);
    chk("b2b_a_out", Out, 32'hFFFF_FFFB);
    step();
    chk("b2b_b_vld", {31'd0, out_valid}, 32'd1);
    chk("b2b_b_out", Out, 32'hFFFD_FFFC);
    step();
    chk("b2b_drain", {31'd0, out_valid}, 32'd0);

    // Stream 4 beats. Stall for 3 cycles after the first output.
    idx = 0; got = 0; stall_left = 0; first_seen = 0;
    mode = 1'b0; popsign = 2'b00;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      in_valid = (idx < 4);
      In = idx + 1;
      stalled = (stall_left > 0);
      out_ready = !stalled;
      if (stalled) stall_left--;
      @(negedge clk);
      if (stalled) begin
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_vld", {31'd0, out_valid}, 32'd1);
        chk("stall_out_stable", Out, got + 1);
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        chk("stream_order", Out, got + 1);
        got++;
        if (!first_seen) begin
          first_seen = 1;
          stall_left = 3;
        end
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_count", got, 32'd4);
    step();
    chk("stream_no_dup", {31'd0, out_valid}, 32'd0);
    chk("cnt_after_stream", {24'd0, ovf_count}, 32'd4);

    // 300 overflowing beats. Then reset while the stream is still running.
    in_valid = 1'b1; mode = 1'b0; In = 32'h8000_0000; popsign = 2'b00;
    for (int i = 0; i < 300; i++) step();
    chk("sat_cnt", {24'd0, ovf_count}, 32'd255);
    chk("sat_vld", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_vld", {31'd0, out_valid}, 32'd0);
    chk("midrst_cnt", {24'd0, ovf_count}, 32'd0);
    chk("midrst_out", Out, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("midrst_flushed", {31'd0, out_valid}, 32'd0);

    // Reset during a stall drops the held output.
    out_ready = 1'b0;
    in_valid = 1'b1; In = 32'h0000_0007; popsign = 2'b01;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("hold_vld", {31'd0, out_valid}, 32'd1);
    chk("hold_out", Out, 32'hFFFF_FFF9);
    chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b1;
    chk("stallrst_vld", {31'd0, out_valid}, 32'd0);
    step();
    chk("stallrst_stay", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apply_sign_pipe.md
APPLY_SIGN_PIPE -- requirements
Module: apply_sign_pipe

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports declared as below and clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  upstream has a {mag, sgn, mode} beat.
REQ-005 in_ready  output  1  block accepts the beat this cycle.
REQ-006 In  input  32  unsigned magnitude; in dual mode, In[31:16] is lane 1 and In[15:0] is lane 2.
REQ-007 popsign  input  2  sign to restore; bit0 is for 32-bit mode and lane 2; bit1 is for lane 1 (ignored in 32-bit mode).
REQ-008 mode  input  1  0 = one 32-bit lane; 1 = two 16-bit lanes.
REQ-009 out_valid  output  1  Out holds a result.
REQ-010 out_ready  input  1  downstream accepts Out.
REQ-011 Out  output  32  two's-complement result, packed the same way as In.
REQ-012 ovf  output  2  per-lane overflow flags travelling with Out; bit0 is for 32-bit mode and lane 2.
REQ-013 ovf_count  output  8  saturating count of accepted beats with any overflow.

Function
REQ-014 The block SHALL perform the inverse of the magnitude/sign split: result = sgn ? (~mag + 1) : mag, per lane, at lane width.
REQ-015 Pipeline SHALL be 2 stages: S1 registers the inputs; S2 computes and registers Out/ovf. Latency from the accept edge to out_valid is 2 cycles.
REQ-016 Handshake: a beat transfers on in_valid&&in_ready; output transfers on out_valid&&out_ready.
REQ-017 advance = !S2_valid || out_ready; in_ready = advance; S1 and S2 load only when advance = 1. Any bubble in S1 propagates as S2_valid = 0.
REQ-018 Out, ovf and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-019 Throughput SHALL be 1 beat/cycle with out_ready held high.
REQ-020 Overflow in a W-bit lane: (sgn = 0 && mag >= 2^(W-1)) || (sgn = 1 && mag > 2^(W-1)). mag = 2^(W-1) with sgn = 1 is legal and yields the most-negative value.
REQ-021 Zero magnitude with sgn = 1 SHALL yield 0 with no overflow.
REQ-022 In dual mode, lanes SHALL be independent; no carry crosses bit 15/16.
REQ-023 In 32-bit mode, ovf[1] SHALL be 0.
REQ-024 ovf_count SHALL increment by 1 when a beat with any ovf bit set is accepted into S2. It saturates at 255 with no wrap.
REQ-025 mode and popsign SHALL be captured per beat; a mode change between beats SHALL take effect with no bubble.

Reset
REQ-026 While rst = 1 at a clk edge, the block SHALL clear S1_valid, out_valid, Out, ovf and ovf_count to 0.
REQ-027 Beats in flight are discarded on reset. in_ready SHALL read 1 in the first cycle after reset deasserts.
REQ-028 Reset asserted mid-stall SHALL drop the held output with no transfer reported.

Configuration
REQ-029 Macro APPLY_SIGN_SAT_EN defined: an overflowing lane SHALL output 2^(W-1)-1 if sgn = 0, else -2^(W-1); ovf is still flagged.
REQ-030 Macro APPLY_SIGN_SAT_EN undefined: an overflowing lane SHALL output the wrapped W-bit result of REQ-014; ovf is still flagged.

Verification
REQ-031 Stimulus: mode = 0, In = 0x00000005, popsign = 1, out_ready = 1. Response: 2 cycles later Out = 0xFFFFFFFB, ovf = 0.
REQ-032 Stimulus: mode = 0, In = 0x80000000, popsign = 1. Response: Out = 0x80000000, ovf = 0. With popsign = 0: ovf = 1, Out = 0x7FFFFFFF if SAT_EN, else 0x80000000.
REQ-033 Stimulus: mode = 1, In = 0x0003_8001, popsign = 2'b10. Response: Out = 0xFFFD_8001, ovf = 2'b01 (lane 2 overflow); with SAT_EN, Out = 0xFFFD_7FFF.
REQ-034 Stimulus: stream 4 beats and hold out_ready = 0 for 3 cycles after the first output. Response: in_ready = 0 during the stall, Out stable, and all 4 beats delivered in order with no loss or duplication.
REQ-035 Stimulus: 300 overflowing beats. Response: ovf_count = 255; asserting rst mid-stream clears out_valid and ovf_count to 0 on the next edge.
